// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares a word-organised data memory between the CPU
// load/store unit and a DMA/debug port. One transaction at a time. Only
// full-word memory accesses are issued. Byte and half stores are done as
// read-modify-write, because all four byte lanes share one write enable.
module dmem_access_ctrl #(
    parameter bit CPU_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic        cpu_rsp_valid,
    output logic        cpu_rsp_err,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_rsp_valid,
    output logic        dma_rsp_err,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Misaligned half/word or an unused size code.
    function automatic logic f_req_err(input logic [2:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            SZ_B, SZ_BU: err = 1'b0;
            SZ_H, SZ_HU: err = lane[0];
            SZ_W:        err = (lane != 2'b00);
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

    // Pick the addressed lane out of a raw word and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [2:0]  size,
                                              input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    res = {{24{b[7]}}, b};
            SZ_BU:   res = {24'h000000, b};
            SZ_H:    res = {{16{h[15]}}, h};
            SZ_HU:   res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Put right-aligned store data into the addressed lane of the old word.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] wdata,
                                            input logic [2:0]  size,
                                            input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_B, SZ_BU: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res[7:0]   = wdata[7:0];
                endcase
            end
            SZ_H, SZ_HU: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic        r_owner_dma;
    logic        r_last_dma;

    logic        r_cpu_rsp_valid;
    logic        r_cpu_rsp_err;
    logic [31:0] r_cpu_rdata;
    logic        r_dma_rsp_valid;
    logic        r_dma_rsp_err;
    logic [31:0] r_dma_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;

    logic        w_idle;
    logic        w_tie_cpu;
    logic        w_grant_cpu;
    logic        w_grant_dma;
    logic        w_accept;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_size;
    logic        w_sel_err;
    logic        w_sel_word_store;

    // Arbitration and selection of the winning request (only used in IDLE).
    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_tie_cpu = CPU_PRIORITY ? 1'b1 : r_last_dma;
        w_grant_cpu = cpu_req_valid & (~dma_req_valid | w_tie_cpu);
        w_grant_dma = dma_req_valid & ~w_grant_cpu;
        w_accept    = w_idle & (w_grant_cpu | w_grant_dma);
        if (w_grant_cpu) begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
            w_sel_size  = cpu_size;
        end else begin
            w_sel_we    = dma_we;
            w_sel_addr  = dma_addr;
            w_sel_wdata = dma_wdata;
            w_sel_size  = SZ_W;
        end
        w_sel_err        = f_req_err(w_sel_size, w_sel_addr[1:0]);
        w_sel_word_store = w_sel_we & (w_sel_size == SZ_W);
    end

    assign cpu_req_ready = w_idle & w_grant_cpu;
    assign dma_req_ready = w_idle & w_grant_dma;

    // Next-state decode for the transaction sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_err) begin
                        w_next_state = ST_ACK;
                    end else if (w_sel_word_store) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RD;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP: begin
                if (r_we) begin
                    w_next_state = ST_WR;
                end else begin
                    w_next_state = ST_ACK;
                end
            end
            ST_WR:   w_next_state = ST_ACK;
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture, memory strobes, merge/extract and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we            <= 1'b0;
            r_lane          <= 2'b00;
            r_wdata         <= 32'h0;
            r_size          <= 3'b000;
            r_owner_dma     <= 1'b0;
            r_last_dma      <= 1'b1;
            r_cpu_rsp_valid <= 1'b0;
            r_cpu_rsp_err   <= 1'b0;
            r_cpu_rdata     <= 32'h0;
            r_dma_rsp_valid <= 1'b0;
            r_dma_rsp_err   <= 1'b0;
            r_dma_rdata     <= 32'h0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_mem_we        <= 1'b0;
        end else begin
            r_mem_we        <= 1'b0;
            r_cpu_rsp_valid <= 1'b0;
            r_cpu_rsp_err   <= 1'b0;
            r_dma_rsp_valid <= 1'b0;
            r_dma_rsp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= w_sel_we;
                        r_lane      <= w_sel_addr[1:0];
                        r_wdata     <= w_sel_wdata;
                        r_size      <= w_sel_size;
                        r_owner_dma <= w_grant_dma;
                        r_last_dma  <= w_grant_dma;
                        if (w_sel_err) begin
                            if (w_grant_dma) begin
                                r_dma_rsp_valid <= 1'b1;
                                r_dma_rsp_err   <= 1'b1;
                            end else begin
                                r_cpu_rsp_valid <= 1'b1;
                                r_cpu_rsp_err   <= 1'b1;
                            end
                        end else begin
                            r_mem_addr <= {w_sel_addr[31:2], 2'b00};
                            if (w_sel_word_store) begin
                                r_mem_wdata <= w_sel_wdata;
                                r_mem_we    <= 1'b1;
                            end
                        end
                    end
                end
                ST_CAP: begin
                    if (r_we) begin
                        r_mem_wdata <= f_merge(mem_rdata, r_wdata, r_size, r_lane);
                        r_mem_we    <= 1'b1;
                    end else if (r_owner_dma) begin
                        r_dma_rdata     <= mem_rdata;
                        r_dma_rsp_valid <= 1'b1;
                    end else begin
                        r_cpu_rdata     <= f_extract(mem_rdata, r_size, r_lane);
                        r_cpu_rsp_valid <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (r_owner_dma) begin
                        r_dma_rsp_valid <= 1'b1;
                    end else begin
                        r_cpu_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rsp_valid = r_cpu_rsp_valid;
    assign cpu_rsp_err   = r_cpu_rsp_err;
    assign cpu_rdata     = r_cpu_rdata;
    assign dma_rsp_valid = r_dma_rsp_valid;
    assign dma_rsp_err   = r_dma_rsp_err;
    assign dma_rdata     = r_dma_rdata;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = r_mem_we;
    assign mem_ctrl      = 3'b010;

endmodule
